// File: rtl/traffic_display.sv
// traffic_display: lamp heads and 4-digit multiplexed 7-segment display
// driven from the intersection controller's phase code and countdowns.
// Build option: TD_ZERO_BLANK_EN blanks a tens digit of 0.

package td_pkg;
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam logic [4:0] LAMP_RED = 5'b10000;
endpackage

// One road: lamp head decode plus countdown sample and BCD split.
// BASE is the first phase code that belongs to this road's green window.
module td_road #(
  parameter logic [3:0] BASE = 4'd0
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [3:0]    state,
  input  logic          emergency,
  input  logic          lit,
  input  logic [5:0]    time_val,
  output logic [4:0]    lamp,
  output td_pkg::bcd_t  bcd
);
  logic [5:0] time_q;
  logic [4:0] rel;
  logic [4:0] lamp_nxt;

  // Phase offset inside this road's 7-code window picks the lamp;
  // odd offsets below 6 are the flashing pre-change phases.
  always_comb begin
    rel      = {1'b0, state} - {1'b0, BASE};
    lamp_nxt = td_pkg::LAMP_RED;
    if (!emergency && rel <= 5'd6) begin
      case (rel[2:1])
        2'd0:    lamp_nxt = 5'b00100;
        2'd1:    lamp_nxt = 5'b00010;
        2'd2:    lamp_nxt = 5'b00001;
        default: lamp_nxt = 5'b01000;
      endcase
      if (rel[0] && !lit) lamp_nxt = 5'b00000;
    end
  end

  // Sample the countdown, split to BCD a cycle later, register the lamps.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      time_q <= '0;
      bcd    <= '0;
      lamp   <= td_pkg::LAMP_RED;
    end else begin
      time_q   <= time_val;
      bcd.tens <= 4'(time_q / 6'd10);
      bcd.ones <= 4'(time_q % 6'd10);
      lamp     <= lamp_nxt;
    end
  end
endmodule

module traffic_display #(
  parameter int SCAN_DIV   = 2500,
  parameter int BLINK_HALF = 2500
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] state,
  input  logic [5:0] ew_time,
  input  logic [5:0] sn_time,
  input  logic       emergency,
  output logic [4:0] ew_lamp,
  output logic [4:0] sn_lamp,
  output logic [7:0] seg,
  output logic [3:0] sel
);
  import td_pkg::*;

  localparam int NUM_ROADS = 2;
  localparam int ROAD_SN   = 0;
  localparam int ROAD_EW   = 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]    state_q;
  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          phase, phase_nxt;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic [7:0]    seg_nxt;
  logic [3:0]    sel_nxt;

  logic [NUM_ROADS-1:0][4:0] lamp;
  logic [NUM_ROADS-1:0][5:0] time_in;
  bcd_t [NUM_ROADS-1:0]      bcd;

  assign time_in[ROAD_SN] = sn_time;
  assign time_in[ROAD_EW] = ew_time;
  assign ew_lamp = lamp[ROAD_EW];
  assign sn_lamp = lamp[ROAD_SN];

  for (genvar r = 0; r < NUM_ROADS; r++) begin : g_road
    td_road #(.BASE((r == ROAD_EW) ? 4'd7 : 4'd0)) u_road (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .state     (state),
      .emergency (emergency),
      .lit       (~phase_nxt),
      .time_val  (time_in[r]),
      .lamp      (lamp[r]),
      .bcd       (bcd[r])
    );
  end

  function automatic logic [7:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 8'hC0;
      4'd1:    seg_pat = 8'hF9;
      4'd2:    seg_pat = 8'hA4;
      4'd3:    seg_pat = 8'hB0;
      4'd4:    seg_pat = 8'h99;
      4'd5:    seg_pat = 8'h92;
      4'd6:    seg_pat = 8'h82;
      4'd7:    seg_pat = 8'hF8;
      4'd8:    seg_pat = 8'h80;
      4'd9:    seg_pat = 8'h90;
      default: seg_pat = 8'hFF;
    endcase
  endfunction

  // Blink phase for this edge; a phase-code change restarts the window lit
  // and beats a coincident wrap. Lamps use this value so the lit half is
  // exactly BLINK_HALF cycles starting the cycle after the change.
  always_comb begin
    blink_cnt_nxt = blink_cnt + 1'b1;
    phase_nxt     = phase;
    if (state != state_q) begin
      blink_cnt_nxt = '0;
      phase_nxt     = 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt_nxt = '0;
      phase_nxt     = ~phase;
    end
  end

  // Pick the digit for the current scan slot and encode it.
  always_comb begin
    case (idx)
      2'd0:    nib = bcd[ROAD_EW].tens;
      2'd1:    nib = bcd[ROAD_EW].ones;
      2'd2:    nib = bcd[ROAD_SN].tens;
      default: nib = bcd[ROAD_SN].ones;
    endcase
    seg_nxt = seg_pat(nib);
`ifdef TD_ZERO_BLANK_EN
    if (!idx[0] && nib == 4'd0) seg_nxt = 8'hFF;
`endif
    if (emergency) seg_nxt = 8'hBF;
    sel_nxt = ~(4'b1000 >> idx);
  end

  // Blink and scan counters plus the registered digit drive; emergency
  // only affects the decoded values, never the counters.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      scan_cnt  <= '0;
      idx       <= '0;
      seg       <= 8'hFF;
      sel       <= 4'b1111;
    end else begin
      state_q   <= state;
      blink_cnt <= blink_cnt_nxt;
      phase     <= phase_nxt;
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg <= seg_nxt;
      sel <= sel_nxt;
    end
  end
endmodule
